// File: rtl/motoro3_run_seq.sv
// motoro3_run_seq: turns operator buttons into run/direction/frequency commands for the 3-phase core.
// Optional input debounce filter: define MOTORO3_RUN_SEQ_DEBOUNCE_EN.
module motoro3_run_seq #(
    parameter int FREQ_W   = 8,
    parameter int FREQ_MIN = 10,
    parameter int FREQ_MAX = 200,
    parameter int STEP     = 5,
    parameter int RAMP_DIV = 1000,
    parameter int DWELL    = 50,
    parameter int DEB_CYC  = 20000
) (
    input  logic              clkI,
    input  logic              rstI,
    input  logic              m3startI,
    input  logic              m3forceStopI,
    input  logic              m3invRotateI,
    input  logic              m3freqINCi,
    input  logic              m3freqDECi,
    output logic              runO,
    output logic              dirO,
    output logic [FREQ_W-1:0] freqO,
    output logic [FREQ_W-1:0] tgtO,
    output logic [2:0]        stateO,
    output logic              busyO
);
    localparam int NB  = 5;
    localparam int PW  = $clog2(RAMP_DIV + 1);
    localparam int DWW = $clog2(DWELL + 1);
    localparam int XW  = FREQ_W + 1;
    localparam logic [XW-1:0] FMIN_X = XW'(FREQ_MIN);
    localparam logic [XW-1:0] FMAX_X = XW'(FREQ_MAX);
    localparam logic [XW-1:0] STEP_X = XW'(STEP);
    localparam int EV_START = 0, EV_FSTOP = 1, EV_INV = 2, EV_INC = 3, EV_DEC = 4;

    if (FREQ_MIN > FREQ_MAX || FREQ_MAX >= (1 << FREQ_W) || STEP < 1 ||
        RAMP_DIV < 1 || DWELL < 1 || DEB_CYC < 1) begin : g_cfg_err
        $error("motoro3_run_seq: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_STOPPING  = 3'd2,
        S_REV_DOWN  = 3'd3,
        S_REV_DWELL = 3'd4
    } state_e;

    logic [NB-1:0] btn, sync1_q, sync2_q, lvl, prev_q, ev;
    assign btn = {m3freqDECi, m3freqINCi, m3invRotateI, m3forceStopI, m3startI};

    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= lvl;
        end
    end

`ifdef MOTORO3_RUN_SEQ_DEBOUNCE_EN
    localparam int DBW = $clog2(DEB_CYC + 1);
    logic [NB-1:0]          flt_q;
    logic [NB-1:0][DBW-1:0] deb_q;

    // Filtered level follows the synchronised input only after DEB_CYC stable cycles.
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            flt_q <= '0;
            deb_q <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync2_q[i] == flt_q[i]) begin
                    deb_q[i] <= '0;
                end else if (deb_q[i] == DBW'(DEB_CYC - 1)) begin
                    flt_q[i] <= sync2_q[i];
                    deb_q[i] <= '0;
                end else begin
                    deb_q[i] <= deb_q[i] + 1'b1;
                end
            end
        end
    end
    assign lvl = flt_q;
`else
    assign lvl = sync2_q;
`endif

    assign ev = lvl & ~prev_q;

    logic [PW-1:0] pre_q;
    logic          tick;
    assign tick = (pre_q == PW'(RAMP_DIV - 1));

    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI)      pre_q <= '0;
        else if (tick) pre_q <= '0;
        else           pre_q <= pre_q + 1'b1;
    end

    state_e            state_q, state_d;
    logic              run_q, run_d, dir_q, dir_d, busy_q, busy_d;
    logic [FREQ_W-1:0] freq_q, freq_d, tgt_q, tgt_d;
    logic [DWW-1:0]    dwell_q, dwell_d;

    // Extended-width arithmetic so +/-STEP never wraps.
    logic [XW-1:0] t_ext, f_ext, t_inc, t_dec, f_dn, f_slew;
    logic          at_min;
    assign t_ext  = {1'b0, tgt_q};
    assign f_ext  = {1'b0, freq_q};
    assign t_inc  = (t_ext + STEP_X > FMAX_X) ? FMAX_X : t_ext + STEP_X;
    assign t_dec  = (t_ext < FMIN_X + STEP_X) ? FMIN_X : t_ext - STEP_X;
    assign f_dn   = (f_ext < FMIN_X + STEP_X) ? FMIN_X : f_ext - STEP_X;
    assign f_slew = (t_ext > f_ext + STEP_X) ? f_ext + STEP_X :
                    (f_ext > t_ext + STEP_X) ? f_ext - STEP_X : t_ext;
    assign at_min = (f_ext <= FMIN_X);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        dir_d   = dir_q;
        freq_d  = freq_q;
        dwell_d = dwell_q;
        tgt_d   = tgt_q;
        if (ev[EV_INC] && !ev[EV_DEC])      tgt_d = t_inc[FREQ_W-1:0];
        else if (ev[EV_DEC] && !ev[EV_INC]) tgt_d = t_dec[FREQ_W-1:0];

        if (ev[EV_FSTOP]) begin
            state_d = S_IDLE;
            run_d   = 1'b0;
            freq_d  = '0;
            dwell_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ev[EV_START]) begin
                        state_d = S_RUN;
                        run_d   = 1'b1;
                        freq_d  = FMIN_X[FREQ_W-1:0];
                    end else if (ev[EV_INV]) begin
                        dir_d = ~dir_q;
                    end
                end
                S_RUN: begin
                    if (ev[EV_START])    state_d = S_STOPPING;
                    else if (ev[EV_INV]) state_d = S_REV_DOWN;
                    else if (tick)       freq_d  = f_slew[FREQ_W-1:0];
                end
                S_STOPPING: begin
                    if (ev[EV_START]) begin
                        state_d = S_RUN;
                    end else if (tick) begin
                        if (at_min) begin
                            state_d = S_IDLE;
                            run_d   = 1'b0;
                            freq_d  = '0;
                        end else begin
                            freq_d = f_dn[FREQ_W-1:0];
                        end
                    end
                end
                S_REV_DOWN: begin
                    if (tick) begin
                        if (at_min) begin
                            state_d = S_REV_DWELL;
                            run_d   = 1'b0;
                            freq_d  = '0;
                            dwell_d = '0;
                        end else begin
                            freq_d = f_dn[FREQ_W-1:0];
                        end
                    end
                end
                S_REV_DWELL: begin
                    if (tick) begin
                        if (dwell_q == DWW'(DWELL - 1)) begin
                            state_d = S_RUN;
                            run_d   = 1'b1;
                            dir_d   = ~dir_q;
                            freq_d  = FMIN_X[FREQ_W-1:0];
                            dwell_d = '0;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    run_d   = 1'b0;
                    freq_d  = '0;
                    dwell_d = '0;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE) && ((state_d != S_RUN) || (freq_d != tgt_d));
    end

    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            dir_q   <= 1'b0;
            freq_q  <= '0;
            tgt_q   <= FMIN_X[FREQ_W-1:0];
            dwell_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            dir_q   <= dir_d;
            freq_q  <= freq_d;
            tgt_q   <= tgt_d;
            dwell_q <= dwell_d;
            busy_q  <= busy_d;
        end
    end

    assign runO   = run_q;
    assign dirO   = dir_q;
    assign freqO  = freq_q;
    assign tgtO   = tgt_q;
    assign stateO = state_q;
    assign busyO  = busy_q;
endmodule

// File: tb/tb_motoro3_run_seq.sv
// Bench for motoro3_run_seq: per-cycle expected outputs queued by a spec model, plus directed checks.
module tb_motoro3_run_seq;
    localparam int FREQ_W = 8, FMIN = 10, FMAX = 30, STEP = 5, RDIV = 4, DWELL = 3, DEB = 8;
    localparam int B_START = 0, B_FSTOP = 1, B_INV = 2, B_INC = 3, B_DEC = 4;

    logic              clkI = 1'b0;
    logic              rstI = 1'b0;
    logic [4:0]        btn  = '0;
    logic              runO, dirO, busyO;
    logic [FREQ_W-1:0] freqO, tgtO;
    logic [2:0]        stateO;

    int n_chk = 0;
    int n_err = 0;

    always #5 clkI = ~clkI;

    motoro3_run_seq #(
        .FREQ_W(FREQ_W), .FREQ_MIN(FMIN), .FREQ_MAX(FMAX), .STEP(STEP),
        .RAMP_DIV(RDIV), .DWELL(DWELL), .DEB_CYC(DEB)
    ) dut (
        .clkI(clkI), .rstI(rstI),
        .m3startI(btn[B_START]), .m3forceStopI(btn[B_FSTOP]), .m3invRotateI(btn[B_INV]),
        .m3freqINCi(btn[B_INC]), .m3freqDECi(btn[B_DEC]),
        .runO(runO), .dirO(dirO), .freqO(freqO), .tgtO(tgtO), .stateO(stateO), .busyO(busyO)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clkI);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_run"}, runO, 0);
        chk({tag, "_dir"}, dirO, 0);
        chk({tag, "_freq"}, freqO, 0);
        chk({tag, "_tgt"}, tgtO, FMIN);
        chk({tag, "_state"}, stateO, 0);
        chk({tag, "_busy"}, busyO, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifndef MOTORO3_RUN_SEQ_DEBOUNCE_EN
    typedef struct packed {
        logic       run;
        logic       dir;
        logic [7:0] freq;
        logic [7:0] tgt;
        logic [2:0] st;
        logic       busy;
    } snap_t;
    snap_t exp_q[$];

    int m_st, m_freq, m_tgt, m_dw, m_pre;
    bit m_run, m_dir;
    bit [4:0] h1, h2, hp;

    // Reference behaviour: button sampled at edge k takes effect at edge k+2.
    always @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            m_st = 0; m_freq = 0; m_tgt = FMIN; m_dw = 0; m_pre = 0;
            m_run = 0; m_dir = 0; h1 = '0; h2 = '0; hp = '0;
            exp_q.delete();
        end else begin : step
            bit [4:0] ev;
            bit tick;
            int nt, d;
            snap_t s;
            ev = h2 & ~hp; hp = h2; h2 = h1; h1 = btn;
            tick = (m_pre == RDIV - 1);
            m_pre = tick ? 0 : m_pre + 1;
            nt = m_tgt;
            if (ev[B_INC] && !ev[B_DEC])      nt = (m_tgt + STEP > FMAX) ? FMAX : m_tgt + STEP;
            else if (ev[B_DEC] && !ev[B_INC]) nt = (m_tgt - STEP < FMIN) ? FMIN : m_tgt - STEP;
            if (ev[B_FSTOP]) begin
                m_st = 0; m_run = 0; m_freq = 0; m_dw = 0;
            end else begin
                case (m_st)
                    0: if (ev[B_START]) begin m_st = 1; m_run = 1; m_freq = FMIN; end
                       else if (ev[B_INV]) m_dir = !m_dir;
                    1: if (ev[B_START]) m_st = 2;
                       else if (ev[B_INV]) m_st = 3;
                       else if (tick) begin
                           d = m_tgt - m_freq;
                           if (d > STEP) m_freq += STEP;
                           else if (d < -STEP) m_freq -= STEP;
                           else m_freq = m_tgt;
                       end
                    2: if (ev[B_START]) m_st = 1;
                       else if (tick) begin
                           if (m_freq == FMIN) begin m_st = 0; m_run = 0; m_freq = 0; end
                           else m_freq = (m_freq - STEP < FMIN) ? FMIN : m_freq - STEP;
                       end
                    3: if (tick) begin
                           if (m_freq == FMIN) begin m_st = 4; m_run = 0; m_freq = 0; m_dw = 0; end
                           else m_freq = (m_freq - STEP < FMIN) ? FMIN : m_freq - STEP;
                       end
                    4: if (tick) begin
                           m_dw++;
                           if (m_dw == DWELL) begin
                               m_dir = !m_dir; m_st = 1; m_run = 1; m_freq = FMIN; m_dw = 0;
                           end
                       end
                    default: m_st = 0;
                endcase
            end
            m_tgt = nt;
            s.run = m_run; s.dir = m_dir; s.freq = 8'(m_freq); s.tgt = 8'(m_tgt);
            s.st = 3'(m_st); s.busy = (m_st != 0) && (m_st != 1 || m_freq != m_tgt);
            exp_q.push_back(s);
        end
    end

    always @(negedge clkI) begin
        if (!rstI && exp_q.size() > 0) begin : mon
            snap_t e;
            e = exp_q.pop_front();
            chk("sb_run", runO, e.run);
            chk("sb_dir", dirO, e.dir);
            chk("sb_freq", freqO, e.freq);
            chk("sb_tgt", tgtO, e.tgt);
            chk("sb_state", stateO, e.st);
            chk("sb_busy", busyO, e.busy);
        end
    end

    // Called at a negedge; button high for exactly one sampling edge.
    task automatic press(input logic [4:0] m);
        btn = m;
        @(negedge clkI);
        btn = '0;
        @(negedge clkI);
    endtask

    task automatic wait_state(input int s, input int lim, input string tag);
        int n = 0;
        while (int'(stateO) != s && n < lim) begin @(negedge clkI); n++; end
        chk(tag, stateO, s);
    endtask

    task automatic wait_freq(input int f, input int lim, input string tag);
        int n = 0;
        while (int'(freqO) != f && n < lim) begin @(negedge clkI); n++; end
        chk(tag, freqO, f);
    endtask

    initial begin : main
        logic dir0;
        #1 rstI = 1'b1;
        cyc(2);
        chk_reset("rst");
        rstI = 1'b0;
        cyc(2);

        press(5'b1 << B_START);
        chk("start_early", runO, 0);
        cyc(1);
        chk("start_run", runO, 1);
        chk("start_freq", freqO, FMIN);
        chk("start_state", stateO, 1);

        press(5'b1 << B_INC); press(5'b1 << B_INC); cyc(1);
        chk("inc2_tgt", tgtO, 20);
        wait_freq(20, 40, "slew_up");
        chk("slew_busy", busyO, 0);

        repeat (10) press(5'b1 << B_INC);
        cyc(1); chk("tgt_sat_hi", tgtO, FMAX);
        repeat (10) press(5'b1 << B_DEC);
        cyc(1); chk("tgt_sat_lo", tgtO, FMIN);
        press((5'b1 << B_INC) | (5'b1 << B_DEC));
        cyc(1); chk("tgt_incdec", tgtO, FMIN);
        press(5'b1 << B_INC); press(5'b1 << B_INC);
        cyc(40);
        chk("resettle", freqO, 20);

        dir0 = dirO;
        press(5'b1 << B_INV); cyc(1);
        chk("rev_down", stateO, 3);
        wait_state(4, 40, "rev_dwell");
        chk("dwell_run", runO, 0);
        chk("dwell_freq", freqO, 0);
        wait_state(1, 40, "rev_restart");
        chk("rev_dir", dirO, !dir0);
        chk("rev_freq", freqO, FMIN);
        wait_freq(20, 40, "rev_slew");

        press(5'b1 << B_START); cyc(1);
        chk("stop_state", stateO, 2);
        wait_state(0, 60, "stop_idle");
        chk("stop_freq", freqO, 0);
        press(5'b1 << B_START); cyc(1);
        wait_freq(20, 40, "restart_slew");
        press(5'b1 << B_START); cyc(1);
        wait_freq(15, 20, "stopping_15");
        press(5'b1 << B_START); cyc(1);
        chk("resume_state", stateO, 1);
        chk("resume_freq", freqO, 15);
        wait_freq(20, 40, "resume_slew");

        dir0 = dirO;
        press(5'b1 << B_INV);
        wait_state(4, 40, "fs_dwell");
        press(5'b1 << B_FSTOP); cyc(1);
        chk("fs_state", stateO, 0);
        chk("fs_run", runO, 0);
        chk("fs_freq", freqO, 0);
        chk("fs_dir", dirO, dir0);
        chk("fs_tgt", tgtO, 20);

        press(5'b1 << B_START); cyc(1);
        chk("sf_run_state", stateO, 1);
        press((5'b1 << B_START) | (5'b1 << B_FSTOP)); cyc(1);
        chk("sf_state", stateO, 0);
        chk("sf_run", runO, 0);

        press(5'b1 << B_INC); press(5'b1 << B_START); cyc(6);
        chk("mid_ramp_state", stateO, 1);
        #1 rstI = 1'b1;
        #1 chk_reset("rst_async");
        cyc(2);
        rstI = 1'b0;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
`else
    initial begin : main_deb
        #1 rstI = 1'b1;
        cyc(2);
        chk_reset("rst");
        rstI = 1'b0;
        cyc(2);

        btn[B_START] = 1'b1; cyc(5);
        btn[B_START] = 1'b0; cyc(20);
        chk("glitch_state", stateO, 0);
        chk("glitch_run", runO, 0);

        btn[B_START] = 1'b1; cyc(10);
        chk("deb_early", runO, 0);
        cyc(1);
        chk("deb_run", runO, 1);
        chk("deb_freq", freqO, FMIN);
        chk("deb_state", stateO, 1);
        btn[B_START] = 1'b0; cyc(20);
        chk("deb_release", stateO, 1);

        #1 rstI = 1'b1;
        #1 chk_reset("rst_async");
        cyc(2);
        rstI = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
`endif
endmodule
